// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush controller for the five-stage integer pipeline.
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   stallreq_if_i     fetch waiting on instruction memory
//   stallreq_id_i     decode load-use hazard
//   ex_start_i        EX operation starts this cycle, ex_cycles_i cycles long
//   flush_i           exception/redirect flush
//   stall_o           hold vector {rsvd, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
//   flush_o           clear all pipeline registers
//   ex_done_o         EX result produced this cycle
//   busy_o            multi-cycle EX operation in progress
//   stall_cnt_o       saturating count of cycles with a nonzero stall vector
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if_i,
    input  logic              stallreq_id_i,
    input  logic              ex_start_i,
    input  logic [CNT_W-1:0]  ex_cycles_i,
    input  logic              flush_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              ex_done_o,
    output logic              busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [PERF_W-1:0] perf;
    logic              start_multi;
    logic              last;
    logic              ex_stall;
    assign start_multi = state == IDLE && ex_start_i && !flush_i && ex_cycles_i > ONE;
    assign last        = state == BUSY && cnt == ONE;
    assign ex_stall    = state == BUSY ? (cnt != ONE && !flush_i) : start_multi;
    // Every output is gated by rst so an asserted reset silences the
    // combinational paths immediately, not just the registered state.
    always_comb begin
        stall_o     = !rst || flush_i ? 6'b000000 :
                      ex_stall        ? 6'b001111 :
                      stallreq_id_i   ? 6'b000111 :
                      stallreq_if_i   ? 6'b000011 : 6'b000000;
        flush_o     = rst && flush_i;
        ex_done_o   = rst && !flush_i && (last || (state == IDLE && ex_start_i && ex_cycles_i <= ONE));
        busy_o      = rst && state == BUSY;
        stall_cnt_o = perf;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            perf  <= '0;
        end else begin
            if (flush_i || last) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (start_multi) begin
                state <= BUSY;
                cnt   <= ex_cycles_i - ONE;
            end else if (state == BUSY) begin
                cnt <= cnt - ONE;
            end
            if (stall_o != 6'b000000 && perf != '1)
                perf <= perf + 1'b1;
        end
    end
endmodule
